// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator on the compare req/ack interface: probes a responder's hidden key over 0..2^W-1.
// Defining CMP_SEARCH_TIMEOUT_EN adds a WAIT-state ack timeout (TIMEOUT cycles) that ends the search with err.
module cmp_search_ctrl #(
  parameter int W       = 4,
  parameter int CW      = $clog2(W + 2),
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cmp_req,
  output logic [W-1:0]  cmp_a,
  input  logic          cmp_ack,
  input  logic [7:0]    cmp_code,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [W-1:0]  result,
  output logic          err,
  output logic [CW-1:0] probe_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] CODE_LT = 8'h01;
  localparam logic [7:0] CODE_EQ = 8'h02;
  localparam logic [7:0] CODE_GT = 8'h04;

  localparam logic [W-1:0] KEY_MAX = {W{1'b1}};

  logic [1:0]   state;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         tmo_hit;

  // Midpoint taken from a W+1 bit sum so lo+hi never wraps.
  function automatic logic [W-1:0] midpoint(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W:1];
  endfunction

`ifdef CMP_SEARCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_cnt;

  // Last silent WAIT cycle of the window; an ack in that same cycle still wins.
  assign tmo_hit = (state == S_WAIT) && !cmp_ack && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else if (!cmp_ack) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign cmp_req = (state == S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cmp_a       <= '0;
      found       <= 1'b0;
      result      <= '0;
      err         <= 1'b0;
      probe_count <= '0;
      lo          <= '0;
      hi          <= KEY_MAX;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lo          <= '0;
            hi          <= KEY_MAX;
            found       <= 1'b0;
            result      <= '0;
            err         <= 1'b0;
            probe_count <= '0;
            state       <= S_PROBE;
          end
        end

        S_PROBE: begin
          cmp_a <= midpoint(lo, hi);
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (cmp_ack) begin
            probe_count <= probe_count + CW'(1);
            // Boundary tests stop the search before lo/hi could step past 0 or KEY_MAX.
            case (cmp_code)
              CODE_EQ: begin
                found  <= 1'b1;
                result <= cmp_a;
                state  <= S_DONE;
              end
              CODE_LT: begin
                if (cmp_a == hi) begin
                  found <= 1'b0;
                  state <= S_DONE;
                end else begin
                  lo    <= cmp_a + W'(1);
                  state <= S_PROBE;
                end
              end
              CODE_GT: begin
                if (cmp_a == lo) begin
                  found <= 1'b0;
                  state <= S_DONE;
                end else begin
                  hi    <= cmp_a - W'(1);
                  state <= S_PROBE;
                end
              end
              default: begin
                err   <= 1'b1;
                found <= 1'b0;
                state <= S_DONE;
              end
            endcase
          end else if (tmo_hit) begin
            err   <= 1'b1;
            found <= 1'b0;
            state <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Initiator side of the 4-bit compare interface. The magnitude comparator answers requests with a one-hot relation code: 8'h01 less, 8'h02 equal, 8'h04 greater.
- This block drives probe values to a comparator-backed responder holding an unknown key. It runs a binary search over 0..2^W-1 and reports the key, or reports not-found or error.
- Sits between control logic (start/done) and any comparator responder, using a req/ack handshake.

Parameters:
- W, 4, operand width; search space 0..2^W-1.
- CW, $clog2(W+2), probe_count width.
- TIMEOUT, 16, max cycles waiting for cmp_ack; used only with CMP_SEARCH_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a search; sampled in IDLE only.
- cmp_req  output  1  probe request; level held until ack.
- cmp_a  output  W  probe value, stable while cmp_req=1.
- cmp_ack  input  1  one-cycle response strobe from the responder.
- cmp_code  input  8  relation of cmp_a to key; valid only with cmp_ack.
- busy  output  1  high from the cycle after start acceptance through DONE.
- done  output  1  one-cycle completion pulse.
- found  output  1  key located; valid from done, held until next start.
- result  output  W  located key; 0 when not found; held until next start.
- err  output  1  illegal code or timeout; held until next start.
- probe_count  output  CW  number of acked probes in the current or last search.

Behaviour:
- Reset (async, immediate): state=IDLE; cmp_req, cmp_a, busy, done, found, result, err, probe_count all 0; lo=0, hi=2^W-1.
- Reset mid-search aborts immediately with no done pulse. A late cmp_ack after reset is ignored in IDLE.
- State IDLE:
  - When start=1: load lo=0, hi=2^W-1; clear found, result, err, probe_count.
  - Go to PROBE.
- State PROBE (1 cycle):
  - cmp_a <= (lo+hi)>>1, computed in W+1 bits with no overflow.
  - Assert cmp_req; go to WAIT.
- State WAIT:
  - Hold cmp_req and cmp_a until cmp_ack=1. Then deassert cmp_req and increment probe_count.
  - On the ack cycle, decode cmp_code:
    - 8'h02: found=1, result=cmp_a; go to DONE.
    - 8'h01 (probe < key): if cmp_a==hi, found=0 and go to DONE; else lo=cmp_a+1 and go to PROBE.
    - 8'h04 (probe > key): if cmp_a==lo, found=0 and go to DONE; else hi=cmp_a-1 and go to PROBE.
    - Any other value: err=1, found=0; go to DONE.
- State DONE (1 cycle): done=1; go to IDLE.
- busy is high in PROBE, WAIT and DONE.
- start outside IDLE is ignored, including start in the DONE cycle. start in the cycle after DONE (IDLE) is accepted.
- cmp_ack outside WAIT is ignored.
- Latency:
  - Worst case W+1 probes.
  - Each probe takes 1 PROBE cycle plus (responder latency+1) WAIT cycles.
  - With a same-cycle responder (cmp_ack in the first WAIT cycle), a k-probe search gives done 2k+1 cycles after the start cycle.
- lo and hi are never allowed to underflow or overflow. The boundary checks above terminate the search before cmp_a-1 at 0 or cmp_a+1 at 2^W-1 is stored.

Optional Feature:
- CMP_SEARCH_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on entering PROBE.
  - If TIMEOUT cycles pass without cmp_ack: drop cmp_req, set err=1, found=0, no probe_count increment; go to DONE.
- CMP_SEARCH_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely until ack or reset.
  - err is set only by an illegal code.

Test Plan:
- Key 11, zero-latency responder, start pulse: probes 7 (01), 11 (02) -> done; found=1, result=11, probe_count=2, err=0.
- Key 0: probes 7, 3, 1 (04 each), then 0 (02) -> found=1, result=0, probe_count=4.
- Key 15: probes 7, 11, 13, 14 (01), then 15 (02) -> found=1, result=15, probe_count=5. Then a responder that always returns 01 -> same probes, 01 at 15 -> found=0, result=0, probe_count=5.
- Responder returns 8'h03 on the first probe -> done after 1 probe; err=1, found=0. Next start clears err, and a normal search succeeds.
- Assert reset during WAIT of probe 2 -> all outputs 0 immediately, no done. A start after reset release runs a full search. start pulsed while busy has no effect.
- With CMP_SEARCH_TIMEOUT_EN and TIMEOUT=16, responder never acks -> cmp_req drops after 16 WAIT cycles; done with err=1, probe_count=0.
